// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one 2-stage pipelined alu among NUM_REQ requesters.
// Optional feature: define ALU_ARB_STATS_EN to add per-requester saturating
// grant counters on port grant_cnt.

package op_code_pkg;
  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_NOT_B = 3'd6;
  // 3'd7 is unassigned; the alu returns 0 for it
endpackage

// Two-stage alu: stage 1 registers the operands, stage 2 registers the result.
module alu #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out
);
  import op_code_pkg::*;

  logic             in_valid_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_c;

  // Stage 1: capture operands
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_r <= 1'b0;
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
    end else begin
      in_valid_r <= in_valid;
      op_r       <= op;
      a_r        <= a;
      b_r        <= b;
    end
  end

  // Operation decode; unknown codes yield 0
  always_comb begin
    result_c = '0;
    case (op_r)
      OP_ADD:   result_c = a_r + b_r;
      OP_SUB:   result_c = a_r - b_r;
      OP_AND:   result_c = a_r & b_r;
      OP_OR:    result_c = a_r | b_r;
      OP_XOR:   result_c = a_r ^ b_r;
      OP_XNOR:  result_c = ~(a_r ^ b_r);
      OP_NOT_B: result_c = ~b_r;
      default:  result_c = '0;
    endcase
  end

  // Stage 2: register result, forced to 0 when not valid
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      out_valid <= in_valid_r;
      out       <= in_valid_r ? result_c : '0;
    end
  end
endmodule

module alu_rr_arbiter #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
`ifdef ALU_ARB_STATS_EN
  output logic [16*NUM_REQ-1:0]    grant_cnt,
`endif
  output logic                     busy
);
  localparam int unsigned TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 16;

  logic [TAG_W-1:0] rr_ptr;
  logic             grant_any;
  logic [TAG_W-1:0] grant_idx;
  logic [TAG_W-1:0] cand;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_out_valid;
  logic [WIDTH-1:0] alu_out;
  logic             tag1_v;
  logic [TAG_W-1:0] tag1_idx;
  logic             tag2_v;
  logic [TAG_W-1:0] tag2_idx;

  // Round-robin scan from rr_ptr; first valid requester wins, none during reset
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = TAG_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (rst) grant_any = 1'b0;
  end

  assign req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  assign busy      = tag1_v | tag2_v | grant_any;

  // Operand mux from the granted slice; all zero when idle
  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_any && grant_idx == TAG_W'(k)) begin
        alu_op = req_op[3*k +: 3];
        alu_a  = req_a[WIDTH*k +: WIDTH];
        alu_b  = req_b[WIDTH*k +: WIDTH];
      end
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (grant_any),
    .op        (alu_op),
    .a         (alu_a),
    .b         (alu_b),
    .out_valid (alu_out_valid),
    .out       (alu_out)
  );

  // Pointer advance past the accepted requester
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
    end
  end

  // Tag pipe tracking the alu stages, plus registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      tag1_v    <= 1'b0;
      tag1_idx  <= '0;
      tag2_v    <= 1'b0;
      tag2_idx  <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      tag1_v    <= grant_any;
      tag1_idx  <= grant_idx;
      tag2_v    <= tag1_v;
      tag2_idx  <= tag1_idx;
      rsp_valid <= alu_out_valid ? (NUM_REQ'(1) << tag2_idx) : '0;
      rsp_data  <= alu_out_valid ? alu_out : '0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating per-requester accept counters
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (grant_any && grant_idx == TAG_W'(k) &&
            grant_cnt[CNT_W*k +: CNT_W] != {CNT_W{1'b1}}) begin
          grant_cnt[CNT_W*k +: CNT_W] <= grant_cnt[CNT_W*k +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter (WIDTH=6, NUM_REQ=4).
module tb_alu_rr_arbiter;
  import op_code_pkg::*;

  localparam int unsigned WIDTH   = 6;
  localparam int unsigned NUM_REQ = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [3*NUM_REQ-1:0]     req_op = '0;
  logic [WIDTH*NUM_REQ-1:0] req_a = '0;
  logic [WIDTH*NUM_REQ-1:0] req_b = '0;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_data;
  logic                     busy;
`ifdef ALU_ARB_STATS_EN
  logic [16*NUM_REQ-1:0]    grant_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0]       t_op [NUM_REQ];
  logic [WIDTH-1:0] t_a  [NUM_REQ];
  logic [WIDTH-1:0] t_b  [NUM_REQ];

  alu_rr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] alu_model(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_XNOR:  return ~(a ^ b);
      OP_NOT_B: return ~b;
      default:  return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_op[3*i +: 3]         = op;
    req_a[WIDTH*i +: WIDTH]  = a;
    req_b[WIDTH*i +: WIDTH]  = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset: ready held low even with all requests pending
    req_valid = 4'hF;
    tick();
    chk("ready_in_rst", req_ready, 4'h0);
    req_valid = '0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("idle_ready_%0d", c), req_ready, 4'h0);
      chk($sformatf("idle_rspv_%0d", c), rsp_valid, 4'h0);
      chk($sformatf("idle_rspd_%0d", c), rsp_data, 6'h00);
      chk($sformatf("idle_busy_%0d", c), busy, 1'b0);
    end

    // Requester 1 alone, AND
    set_req(1, OP_AND, 6'h3C, 6'h0F);
    req_valid = 4'b0010;
    #1;
    chk("r1_ready", req_ready, 4'b0010);
    chk("r1_busy", busy, 1'b1);
    tick();
    req_valid = '0;
    chk("r1_rsp_t0", rsp_valid, 4'b0000);
    tick();
    chk("r1_rsp_t1", rsp_valid, 4'b0000);
    chk("r1_busy_t1", busy, 1'b1);
    tick();
    chk("r1_rsp_v", rsp_valid, 4'b0010);
    chk("r1_rsp_d", rsp_data, 6'h0C);
    tick();
    chk("r1_rsp_gone", rsp_valid, 4'b0000);
    chk("r1_busy_end", busy, 1'b0);

    // All four requesting every cycle
    do_reset();
    t_op[0] = OP_ADD; t_a[0] = 6'h25; t_b[0] = 6'h1F;
    t_op[1] = OP_SUB; t_a[1] = 6'h10; t_b[1] = 6'h20;
    t_op[2] = OP_XOR; t_a[2] = 6'h2A; t_b[2] = 6'h3F;
    t_op[3] = 3'd7;   t_a[3] = 6'h3F; t_b[3] = 6'h3F;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, t_op[i], t_a[i], t_b[i]);
    for (int c = 0; c < 12; c++) begin
      logic [NUM_REQ-1:0] exp_rdy;
      exp_rdy = '0;
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) exp_rdy[c % 4] = 1'b1;
      chk($sformatf("rr_ready_%0d", c), req_ready, exp_rdy);
      if (c >= 3 && c < 11) begin
        logic [NUM_REQ-1:0] exp_v;
        int g;
        g = (c - 3) % 4;
        exp_v = '0;
        exp_v[g] = 1'b1;
        chk($sformatf("rr_rspv_%0d", c), rsp_valid, exp_v);
        chk($sformatf("rr_rspd_%0d", c), rsp_data, alu_model(t_op[g], t_a[g], t_b[g]));
      end else begin
        chk($sformatf("rr_rspv_%0d", c), rsp_valid, 4'h0);
      end
      tick();
    end

    // Back-to-back XNOR on req2 then NOT_B on req3
    do_reset();
    set_req(2, OP_XNOR, 6'h2A, 6'h15);
    set_req(3, OP_NOT_B, 6'h00, 6'h01);
    req_valid = 4'b0100;
    #1;
    chk("b2b_ready2", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("b2b_ready3", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    chk("b2b_rsp_none", rsp_valid, 4'b0000);
    tick();
    chk("b2b_rsp2_v", rsp_valid, 4'b0100);
    chk("b2b_rsp2_d", rsp_data, 6'h00);
    tick();
    chk("b2b_rsp3_v", rsp_valid, 4'b1000);
    chk("b2b_rsp3_d", rsp_data, 6'h3E);
    tick();
    chk("b2b_rsp_end", rsp_valid, 4'b0000);
    chk("b2b_busy_end", busy, 1'b0);

    // Reset while a request is in flight
    do_reset();
    set_req(0, OP_OR, 6'h01, 6'h02);
    req_valid = 4'b0001;
    #1;
    chk("rst_mid_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("rst_mid_rspv_%0d", c), rsp_valid, 4'b0000);
      tick();
    end
    req_valid = 4'hF;
    #1;
    chk("rst_mid_ptr0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0011;
    #1;
    chk("rereq_lowest", req_ready, 4'b0010);
    tick();
    req_valid = '0;

`ifdef ALU_ARB_STATS_EN
    // Saturating counter on requester 3
    do_reset();
    set_req(3, OP_ADD, 6'h01, 6'h01);
    req_valid = 4'b1000;
    repeat (70000) tick();
    req_valid = '0;
    tick();
    chk("cnt3_sat", grant_cnt[63:48], 16'hFFFF);
    chk("cnt_others", grant_cnt[47:0], 48'h0);
    do_reset();
    #1;
    chk("cnt_cleared", grant_cnt, 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
